// File: rtl/mnist_uart_pkg.sv
// Shared constants, state encoding and frame-length helper for the MNIST result UART path.
// Optional checksum byte is selected by RESULT_FRAMER_CHECKSUM_EN.
package mnist_uart_pkg;

    localparam logic [7:0] FRAME_HDR0 = 8'hAA;
    localparam logic [7:0] FRAME_HDR1 = 8'h55;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } framer_state_t;

`ifdef RESULT_FRAMER_CHECKSUM_EN
    localparam bit CHECKSUM_EN = 1'b1;
`else
    localparam bit CHECKSUM_EN = 1'b0;
`endif

    function automatic int frame_len(input int num_classes, input bit checksum_en);
        return 3 + num_classes + (checksum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/result_uart_framer_if.sv
// Result handshake and uart_tx byte interface of the result framer.
// master = surrounding system (result source + uart_tx), slave = the framer.
interface result_uart_framer_if #(
    parameter int NUM_CLASSES = 10
);
    logic                     result_valid;
    logic                     result_ready;
    logic [3:0]               result_class;
    logic [NUM_CLASSES*8-1:0] result_scores;
    logic [7:0]               uart_data;
    logic                     uart_tx_en;
    logic                     uart_tx_busy;
    logic                     frame_busy;
    logic                     frame_done;

    modport master (
        output result_valid, result_class, result_scores, uart_tx_busy,
        input  result_ready, uart_data, uart_tx_en, frame_busy, frame_done
    );

    modport slave (
        input  result_valid, result_class, result_scores, uart_tx_busy,
        output result_ready, uart_data, uart_tx_en, frame_busy, frame_done
    );
endinterface

// File: rtl/result_uart_framer.sv
// Latches one inference result and streams it as AA 55 class scores.. [checksum] to uart_tx,
// one byte per uart_tx_en pulse. Checksum byte present only with RESULT_FRAMER_CHECKSUM_EN.
module result_uart_framer
    import mnist_uart_pkg::*;
#(
    parameter int NUM_CLASSES = 10,
    parameter int GAP_CYCLES  = 40
) (
    input logic                  sys_clk,
    input logic                  sys_rst_n,
    result_uart_framer_if.slave  link
);

    localparam int FRAME_LEN = frame_len(NUM_CLASSES, CHECKSUM_EN);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    framer_state_t            state, state_next;
    logic [IDX_W-1:0]         byte_idx;
    logic [GAP_W-1:0]         gap_cnt;
    logic [3:0]               class_q;
    logic [NUM_CLASSES*8-1:0] scores_q;
    logic [7:0]               frame_byte;
    logic                     accept, last_byte, gap_expired, tx_en_next, done_next;

    assign accept      = link.result_valid && (state == IDLE);
    assign last_byte   = (byte_idx == LAST_IDX);
    assign gap_expired = (gap_cnt == '0);

    // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (link.result_valid) state_next = LOAD;
            LOAD:      state_next = WAIT_BUSY;
            WAIT_BUSY: if (link.uart_tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!link.uart_tx_busy) state_next = GAP;
            GAP:       if (gap_expired) state_next = last_byte ? IDLE : LOAD;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        link.result_ready = (state == IDLE);
        link.frame_busy   = (state != IDLE);
        tx_en_next        = (state == LOAD);
        done_next         = (state == GAP) && gap_expired && last_byte;
    end

`ifdef RESULT_FRAMER_CHECKSUM_EN
    logic [7:0] checksum_q;

    // Sum is taken as each payload byte is loaded, so it is complete by the checksum slot.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            checksum_q <= 8'h00;
        end else if (accept) begin
            checksum_q <= 8'h00;
        end else if (state == LOAD && byte_idx >= IDX_W'(2) && byte_idx <= IDX_W'(2 + NUM_CLASSES)) begin
            checksum_q <= checksum_q + frame_byte;
        end
    end
`endif

    always_comb begin
        frame_byte = 8'h00;
        if (byte_idx == IDX_W'(0))      frame_byte = FRAME_HDR0;
        else if (byte_idx == IDX_W'(1)) frame_byte = FRAME_HDR1;
        else if (byte_idx == IDX_W'(2)) frame_byte = {4'h0, class_q};
`ifdef RESULT_FRAMER_CHECKSUM_EN
        else if (byte_idx == LAST_IDX)  frame_byte = checksum_q;
`endif
        else begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (byte_idx == IDX_W'(i + 3)) frame_byte = scores_q[8*i +: 8];
            end
        end
    end

    // NOTE: payload registers carry no reset; they are always written on accept before any byte is read.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            class_q  <= link.result_class;
            scores_q <= link.result_scores;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_idx        <= '0;
            gap_cnt         <= '0;
            link.uart_data  <= 8'h00;
            link.uart_tx_en <= 1'b0;
            link.frame_done <= 1'b0;
        end else begin
            link.uart_tx_en <= tx_en_next;
            link.frame_done <= done_next;
            if (tx_en_next) link.uart_data <= frame_byte;

            if (accept)
                byte_idx <= '0;
            else if (state == GAP && gap_expired && !last_byte)
                byte_idx <= byte_idx + IDX_W'(1);

            // Gap starts when uart_tx drops busy, giving the stop bit time to finish.
            if (state == WAIT_DONE && !link.uart_tx_busy)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP && !gap_expired)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_result_uart_framer.sv
// Self-checking bench for result_uart_framer: behavioural uart_tx busy model, byte capture,
// table vectors, randomized frames against a frame model, and multi-cycle corner sequences.
module tb_result_uart_framer;

    localparam int NC       = 10;
    localparam int GAP      = 40;
    localparam int BUSY_LEN = 20;
`ifdef RESULT_FRAMER_CHECKSUM_EN
    localparam int FLEN = 14;
`else
    localparam int FLEN = 13;
`endif

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [3:0]      cls;
        logic [NC*8-1:0] scores;
        logic [7:0]      cks;
    } vec_t;

    logic sys_clk;
    logic sys_rst_n;
    result_uart_framer_if #(.NUM_CLASSES(NC)) link ();

    result_uart_framer #(.NUM_CLASSES(NC), .GAP_CYCLES(GAP)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .link      (link)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int  total = 0;
    int  bad   = 0;
    bq_t got;
    int  done_cnt  = 0;
    int  cyc       = 0;
    int  last_fall = -1000;
    int  busy_cnt  = 0;
    bit  en_prev   = 1'b0;
    bit  done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // uart_tx stand-in: captures the byte on each start pulse and holds busy for BUSY_LEN cycles.
    always @(negedge sys_clk) begin
        cyc++;
        if (link.uart_tx_en === 1'b1) begin
            check("en_while_busy", 32'(busy_cnt == 0), 1);
            check("en_gap", 32'((cyc - last_fall) >= GAP), 1);
            check("en_twice", 32'(en_prev), 0);
            got.push_back(link.uart_data);
            busy_cnt = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) last_fall = cyc;
        end
        link.uart_tx_busy = (busy_cnt > 0);
        en_prev = (link.uart_tx_en === 1'b1);
        if (link.frame_done === 1'b1) begin
            done_cnt++;
            check("done_width", 32'(done_prev), 0);
        end
        done_prev = (link.frame_done === 1'b1);
    end

    function automatic bq_t model_frame(input logic [3:0] cls, input logic [NC*8-1:0] sc);
        bq_t q;
        int  sum;
        sum = int'(cls);
        q.push_back(8'hAA);
        q.push_back(8'h55);
        q.push_back({4'h0, cls});
        for (int i = 0; i < NC; i++) begin
            q.push_back(sc[8*i +: 8]);
            sum += int'(sc[8*i +: 8]);
        end
`ifdef RESULT_FRAMER_CHECKSUM_EN
        q.push_back(8'(sum % 256));
`endif
        return q;
    endfunction

    function automatic logic [NC*8-1:0] rand_scores();
        logic [NC*8-1:0] r;
        for (int i = 0; i < NC; i++) r[8*i +: 8] = 8'($urandom);
        return r;
    endfunction

    task automatic compare_frame(input string tag, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
        end
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (link.result_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check("accept_seen", 32'(ok), 1);
    endtask

    task automatic wait_done(input int target);
        bit ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge sys_clk);
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(ok), 1);
    endtask

    task automatic send(input logic [3:0] cls, input logic [NC*8-1:0] sc);
        @(negedge sys_clk);
        link.result_valid  = 1'b1;
        link.result_class  = cls;
        link.result_scores = sc;
        wait_ready();
        @(posedge sys_clk);
        @(negedge sys_clk);
        link.result_valid  = 1'b0;
        link.result_class  = 4'($urandom);
        link.result_scores = rand_scores();
    endtask

    initial begin
        vec_t            vecs [4];
        logic [3:0]      ca, cb;
        logic [NC*8-1:0] sa, sb;
        int              d0, n;
        bit              seen;

        for (int i = 0; i < NC; i++) begin
            vecs[0].scores[8*i +: 8] = 8'(i + 1);
            vecs[1].scores[8*i +: 8] = 8'hFF;
            vecs[2].scores[8*i +: 8] = 8'h00;
            vecs[3].scores[8*i +: 8] = 8'h80;
        end
        vecs[0].cls = 4'd7;  vecs[0].cks = 8'h3E;
        vecs[1].cls = 4'd9;  vecs[1].cks = 8'hFF;
        vecs[2].cls = 4'd0;  vecs[2].cks = 8'h00;
        vecs[3].cls = 4'd15; vecs[3].cks = 8'h0F;

        link.result_valid  = 1'b0;
        link.result_class  = 4'h0;
        link.result_scores = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_ready", 32'(link.result_ready), 1);
        check("rst_tx_en", 32'(link.uart_tx_en), 0);
        check("rst_data", link.uart_data, 8'h00);
        check("rst_busy", 32'(link.frame_busy), 0);
        check("rst_done", 32'(link.frame_done), 0);

        // First-byte latency: accept edge N, pulse with AA registered on edge N+1.
        got.delete();
        d0 = done_cnt;
        ca = 4'd3;
        sa = rand_scores();
        link.result_valid  = 1'b1;
        link.result_class  = ca;
        link.result_scores = sa;
        wait_ready();
        @(posedge sys_clk); #1;
        check("lat_ready_low", 32'(link.result_ready), 0);
        check("lat_busy", 32'(link.frame_busy), 1);
        check("lat_no_en_yet", 32'(link.uart_tx_en), 0);
        @(posedge sys_clk); #1;
        check("lat_en", 32'(link.uart_tx_en), 1);
        check("lat_data", link.uart_data, 8'hAA);
        @(negedge sys_clk);
        link.result_valid = 1'b0;
        wait_done(d0 + 1);
        compare_frame("lat", model_frame(ca, sa));

        for (int v = 0; v < 4; v++) begin
            got.delete();
            d0 = done_cnt;
            send(vecs[v].cls, vecs[v].scores);
            wait_done(d0 + 1);
            check($sformatf("tbl%0d_pulses", v), got.size(), FLEN);
            compare_frame($sformatf("tbl%0d", v), model_frame(vecs[v].cls, vecs[v].scores));
`ifdef RESULT_FRAMER_CHECKSUM_EN
            if (got.size() == FLEN) check($sformatf("tbl%0d_cks", v), got[FLEN-1], vecs[v].cks);
`endif
            repeat (5) @(negedge sys_clk);
            check($sformatf("tbl%0d_done_cnt", v), done_cnt - d0, 1);
        end

        for (int r = 0; r < 12; r++) begin
            got.delete();
            d0 = done_cnt;
            ca = 4'($urandom_range(0, 15));
            sa = rand_scores();
            send(ca, sa);
            wait_done(d0 + 1);
            compare_frame($sformatf("rnd%0d", r), model_frame(ca, sa));
        end

        // Back-to-back: valid held high; second result must be taken on the frame_done cycle.
        got.delete();
        d0 = done_cnt;
        ca = 4'($urandom_range(0, 9));
        sa = rand_scores();
        cb = 4'($urandom_range(0, 9));
        sb = rand_scores();
        @(negedge sys_clk);
        link.result_valid  = 1'b1;
        link.result_class  = ca;
        link.result_scores = sa;
        wait_ready();
        @(posedge sys_clk);
        @(negedge sys_clk);
        link.result_class  = cb;
        link.result_scores = sb;
        seen = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge sys_clk);
            if (link.frame_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b_done_seen", 32'(seen), 1);
        check("b2b_ready_on_done", 32'(link.result_ready), 1);
        @(posedge sys_clk); #1;
        check("b2b_second_accepted", 32'(link.frame_busy), 1);
        @(negedge sys_clk);
        link.result_valid = 1'b0;
        wait_done(d0 + 2);
        begin
            bq_t exp;
            exp = model_frame(ca, sa);
            exp = {exp, model_frame(cb, sb)};
            compare_frame("b2b", exp);
        end

        // Valid raised with a different class mid-frame must be ignored.
        got.delete();
        d0 = done_cnt;
        ca = 4'd5;
        sa = rand_scores();
        send(ca, sa);
        for (int c = 0; c < 3000 && got.size() < 3; c++) @(negedge sys_clk);
        link.result_valid = 1'b1;
        link.result_class = 4'd2;
        for (int c = 0; c < 3000 && got.size() < 6; c++) @(negedge sys_clk);
        check("vwb_ready_low", 32'(link.result_ready), 0);
        link.result_valid = 1'b0;
        wait_done(d0 + 1);
        compare_frame("vwb", model_frame(ca, sa));
        repeat (5) @(negedge sys_clk);
        check("vwb_no_extra_accept", 32'(link.frame_busy), 0);

        // Reset during byte 5 aborts the frame; next frame restarts cleanly.
        got.delete();
        ca = 4'd8;
        sa = rand_scores();
        send(ca, sa);
        for (int c = 0; c < 3000 && got.size() < 5; c++) @(negedge sys_clk);
        check("mid_reached_b5", 32'(got.size() >= 5), 1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(link.result_ready), 1);
        check("mid_rst_busy", 32'(link.frame_busy), 0);
        check("mid_rst_data", link.uart_data, 8'h00);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        n = got.size();
        repeat (150) @(negedge sys_clk);
        check("mid_no_en_after_rst", got.size(), n);
        check("mid_idle", 32'(link.frame_busy), 0);
        got.delete();
        d0 = done_cnt;
        cb = 4'd1;
        sb = rand_scores();
        send(cb, sb);
        wait_done(d0 + 1);
        compare_frame("post_rst", model_frame(cb, sb));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
